// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store memory sequencer: memop codes,
// FSM states, latched request record and size helpers.
package lsu_mem_ctrl_pkg;

   localparam logic [1:0] MEMOP_B    = 2'd3;
   localparam logic [1:0] MEMOP_H    = 2'd2;
   localparam logic [1:0] MEMOP_W    = 2'd1;
   localparam logic [1:0] MEMOP_D    = 2'd0;
   localparam int         MEMOP_SIGN = 2;

   typedef enum logic [2:0] {
      IDLE,
      B0_REQ,
      B0_WAIT,
      B1_REQ,
      B1_WAIT,
      RESP
   } lsu_state_e;

   typedef struct packed {
      logic [2:0]  off;
      logic [2:0]  memop;
      logic        wen;
      logic [63:0] wdata;
      logic        two_beat;
   } lsu_req_t;

   function automatic logic [7:0] size_bytemask(input logic [1:0] size);
      case (size)
         MEMOP_B: size_bytemask = 8'h01;
         MEMOP_H: size_bytemask = 8'h03;
         MEMOP_W: size_bytemask = 8'h0F;
         default: size_bytemask = 8'hFF;
      endcase
   endfunction

   function automatic logic [3:0] size_nbytes(input logic [1:0] size);
      case (size)
         MEMOP_B: size_nbytes = 4'd1;
         MEMOP_H: size_nbytes = 4'd2;
         MEMOP_W: size_nbytes = 4'd4;
         default: size_nbytes = 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response bundle and memory-port beat bundle.
interface lsu_core_if #(
   parameter int ADDR_W = 64
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [2:0]        req_memop;
   logic              req_wen;
   logic [63:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [63:0]       rsp_rdata;
   logic              rsp_err;

   modport slave (
      input  req_valid, req_addr, req_memop, req_wen, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport master (
      output req_valid, req_addr, req_memop, req_wen, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

interface lsu_mem_if #(
   parameter int ADDR_W = 64
);
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wen;
   logic [63:0]       mem_wdata;
   logic [7:0]        mem_wmask;
   logic              mem_rsp_valid;
   logic [63:0]       mem_rsp_rdata;

   modport master (
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );

   modport slave (
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );
endinterface

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational byte-lane alignment: write image and mask across two beats,
// boundary-crossing detection, and load extraction with zero/sign extension.
module lsu_align
   import lsu_mem_ctrl_pkg::*;
(
   input  logic [2:0]   off,
   input  logic [2:0]   memop,
   input  logic [63:0]  wdata,
   input  logic [63:0]  rd_lo,
   input  logic [63:0]  rd_hi,
   output logic [127:0] wimg,
   output logic [15:0]  wmask_wide,
   output logic         two_beat,
   output logic [63:0]  load_data
);
   logic [63:0] rd_shift;
   logic        sgn;

   always_comb begin
      wimg       = {64'd0, wdata} << {off, 3'b000};
      wmask_wide = {8'd0, size_bytemask(memop[1:0])} << off;
      two_beat   = ({1'b0, off} + size_nbytes(memop[1:0])) > 4'd8;
      rd_shift   = 64'({rd_hi, rd_lo} >> {off, 3'b000});
      sgn        = memop[MEMOP_SIGN];
      case (memop[1:0])
         MEMOP_B: load_data = {{56{sgn & rd_shift[7]}},  rd_shift[7:0]};
         MEMOP_H: load_data = {{48{sgn & rd_shift[15]}}, rd_shift[15:0]};
         MEMOP_W: load_data = {{32{sgn & rd_shift[31]}}, rd_shift[31:0]};
         default: load_data = rd_shift;
      endcase
   end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: latches one core request, issues one or two aligned
// 8-byte beats to memory and returns the reassembled, extended load result.
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 64,
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic      clk,
   input  logic      rst,
   lsu_core_if.slave core,
   lsu_mem_if.master mem
);
   lsu_state_e        state_reg;
   lsu_req_t          req_reg;
   logic [63:0]       lo_reg;
   logic [63:0]       hi_reg;
   logic              req_ready_reg;
   logic              rsp_valid_reg;
   logic              rsp_err_reg;
   logic [63:0]       rsp_rdata_reg;
   logic              mem_req_valid_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic              mem_wen_reg;
   logic [63:0]       mem_wdata_reg;
   logic [7:0]        mem_wmask_reg;

   logic              idle;
   logic [2:0]        al_off;
   logic [2:0]        al_memop;
   logic [63:0]       al_wdata;
   logic [63:0]       al_lo;
   logic [63:0]       al_hi;
   logic [127:0]      wimg;
   logic [15:0]       wmask_wide;
   logic              two_beat;
   logic [63:0]       load_data;

   // One aligner serves both the incoming request (IDLE) and the latched one.
   // Beat read data is fed through directly so the result can be registered
   // on the same edge that captures the final beat.
   assign idle     = (state_reg == IDLE);
   assign al_off   = idle ? core.req_addr[2:0] : req_reg.off;
   assign al_memop = idle ? core.req_memop     : req_reg.memop;
   assign al_wdata = idle ? core.req_wdata     : req_reg.wdata;
   assign al_lo    = (state_reg == B0_WAIT) ? mem.mem_rsp_rdata : lo_reg;
   assign al_hi    = (state_reg == B1_WAIT) ? mem.mem_rsp_rdata : hi_reg;

   lsu_align u_align (
      .off        (al_off),
      .memop      (al_memop),
      .wdata      (al_wdata),
      .rd_lo      (al_lo),
      .rd_hi      (al_hi),
      .wimg       (wimg),
      .wmask_wide (wmask_wide),
      .two_beat   (two_beat),
      .load_data  (load_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= IDLE;
         req_reg           <= '0;
         lo_reg            <= '0;
         hi_reg            <= '0;
         req_ready_reg     <= 1'b1;
         rsp_valid_reg     <= 1'b0;
         rsp_err_reg       <= 1'b0;
         rsp_rdata_reg     <= '0;
         mem_req_valid_reg <= 1'b0;
         mem_addr_reg      <= '0;
         mem_wen_reg       <= 1'b0;
         mem_wdata_reg     <= '0;
         mem_wmask_reg     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (core.req_valid) begin
                  req_reg.off      <= core.req_addr[2:0];
                  req_reg.memop    <= core.req_memop;
                  req_reg.wen      <= core.req_wen;
                  req_reg.wdata    <= core.req_wdata;
                  req_reg.two_beat <= two_beat;
                  lo_reg           <= '0;
                  hi_reg           <= '0;
                  req_ready_reg    <= 1'b0;
                  if (two_beat && !SPLIT_EN) begin
                     state_reg     <= RESP;
                     rsp_valid_reg <= 1'b1;
                     rsp_err_reg   <= 1'b1;
                     rsp_rdata_reg <= '0;
                  end else begin
                     state_reg         <= B0_REQ;
                     mem_req_valid_reg <= 1'b1;
                     mem_addr_reg      <= {core.req_addr[ADDR_W-1:3], 3'b000};
                     mem_wen_reg       <= core.req_wen;
                     mem_wdata_reg     <= wimg[63:0];
                     mem_wmask_reg     <= core.req_wen ? wmask_wide[7:0] : 8'h00;
                  end
               end
            end
            B0_REQ: begin
               if (mem.mem_req_ready) begin
                  mem_req_valid_reg <= 1'b0;
                  state_reg         <= B0_WAIT;
               end
            end
            B0_WAIT: begin
               if (mem.mem_rsp_valid) begin
                  lo_reg <= mem.mem_rsp_rdata;
                  if (req_reg.two_beat) begin
                     state_reg         <= B1_REQ;
                     mem_req_valid_reg <= 1'b1;
                     mem_addr_reg      <= mem_addr_reg + ADDR_W'(8);
                     mem_wdata_reg     <= wimg[127:64];
                     mem_wmask_reg     <= req_reg.wen ? wmask_wide[15:8] : 8'h00;
                  end else begin
                     state_reg     <= RESP;
                     rsp_valid_reg <= 1'b1;
                     rsp_rdata_reg <= req_reg.wen ? 64'd0 : load_data;
                  end
               end
            end
            B1_REQ: begin
               if (mem.mem_req_ready) begin
                  mem_req_valid_reg <= 1'b0;
                  state_reg         <= B1_WAIT;
               end
            end
            B1_WAIT: begin
               if (mem.mem_rsp_valid) begin
                  hi_reg        <= mem.mem_rsp_rdata;
                  state_reg     <= RESP;
                  rsp_valid_reg <= 1'b1;
                  rsp_rdata_reg <= req_reg.wen ? 64'd0 : load_data;
               end
            end
            RESP: begin
               if (core.rsp_ready) begin
                  state_reg     <= IDLE;
                  rsp_valid_reg <= 1'b0;
                  rsp_err_reg   <= 1'b0;
                  rsp_rdata_reg <= '0;
                  req_ready_reg <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign core.req_ready    = req_ready_reg;
   assign core.rsp_valid    = rsp_valid_reg;
   assign core.rsp_rdata    = rsp_rdata_reg;
   assign core.rsp_err      = rsp_err_reg;
   assign mem.mem_req_valid = mem_req_valid_reg;
   assign mem.mem_addr      = mem_addr_reg;
   assign mem.mem_wen       = mem_wen_reg;
   assign mem.mem_wdata     = mem_wdata_reg;
   assign mem.mem_wmask     = mem_wmask_reg;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: beat and response scoreboards, two DUTs
// (splitting enabled / disabled) sharing one stimulus path selected by sel.
module tb_lsu_mem_ctrl;

   typedef struct {
      logic [63:0] addr;
      logic        wen;
      logic [63:0] wdata;
      logic [7:0]  mask;
   } beat_t;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic [63:0] req_addr = '0;
   logic [2:0]  req_memop = '0;
   logic        req_wen = 1'b0;
   logic [63:0] req_wdata = '0;
   logic        rsp_ready = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_rsp_valid = 1'b0;
   logic [63:0] mem_rdata = '0;

   beat_t       exp_beat_q[$];
   logic [63:0] mem_data_q[$];
   rsp_t        exp_rsp_q[$];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   lsu_core_if #(.ADDR_W(64)) c0 ();
   lsu_core_if #(.ADDR_W(64)) c1 ();
   lsu_mem_if  #(.ADDR_W(64)) m0 ();
   lsu_mem_if  #(.ADDR_W(64)) m1 ();

   assign c0.req_valid     = req_valid & ~sel;
   assign c1.req_valid     = req_valid & sel;
   assign c0.req_addr      = req_addr;
   assign c1.req_addr      = req_addr;
   assign c0.req_memop     = req_memop;
   assign c1.req_memop     = req_memop;
   assign c0.req_wen       = req_wen;
   assign c1.req_wen       = req_wen;
   assign c0.req_wdata     = req_wdata;
   assign c1.req_wdata     = req_wdata;
   assign c0.rsp_ready     = rsp_ready & ~sel;
   assign c1.rsp_ready     = rsp_ready & sel;
   assign m0.mem_req_ready = mem_ready & ~sel;
   assign m1.mem_req_ready = mem_ready & sel;
   assign m0.mem_rsp_valid = mem_rsp_valid & ~sel;
   assign m1.mem_rsp_valid = mem_rsp_valid & sel;
   assign m0.mem_rsp_rdata = mem_rdata;
   assign m1.mem_rsp_rdata = mem_rdata;

   lsu_mem_ctrl #(.ADDR_W(64), .SPLIT_EN(1'b1)) dut0 (
      .clk  (clk),
      .rst  (rst),
      .core (c0),
      .mem  (m0)
   );

   lsu_mem_ctrl #(.ADDR_W(64), .SPLIT_EN(1'b0)) dut1 (
      .clk  (clk),
      .rst  (rst),
      .core (c1),
      .mem  (m1)
   );

   wire        o_req_ready     = sel ? c1.req_ready     : c0.req_ready;
   wire        o_rsp_valid     = sel ? c1.rsp_valid     : c0.rsp_valid;
   wire [63:0] o_rsp_rdata     = sel ? c1.rsp_rdata     : c0.rsp_rdata;
   wire        o_rsp_err       = sel ? c1.rsp_err       : c0.rsp_err;
   wire        o_mem_req_valid = sel ? m1.mem_req_valid : m0.mem_req_valid;
   wire [63:0] o_mem_addr      = sel ? m1.mem_addr      : m0.mem_addr;
   wire        o_mem_wen       = sel ? m1.mem_wen       : m0.mem_wen;
   wire [63:0] o_mem_wdata     = sel ? m1.mem_wdata     : m0.mem_wdata;
   wire [7:0]  o_mem_wmask     = sel ? m1.mem_wmask     : m0.mem_wmask;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"},     o_req_ready,     64'd1);
      check({tag, "_rsp_valid"},     o_rsp_valid,     64'd0);
      check({tag, "_rsp_rdata"},     o_rsp_rdata,     64'd0);
      check({tag, "_rsp_err"},       o_rsp_err,       64'd0);
      check({tag, "_mem_req_valid"}, o_mem_req_valid, 64'd0);
      check({tag, "_mem_addr"},      o_mem_addr,      64'd0);
      check({tag, "_mem_wen"},       o_mem_wen,       64'd0);
      check({tag, "_mem_wdata"},     o_mem_wdata,     64'd0);
      check({tag, "_mem_wmask"},     o_mem_wmask,     64'd0);
   endtask

   task automatic push_beat(input logic [63:0] a, input logic w, input logic [63:0] wd,
                            input logic [7:0] mk, input logic [63:0] rd);
      beat_t b;
      b.addr = a; b.wen = w; b.wdata = wd; b.mask = mk;
      exp_beat_q.push_back(b);
      mem_data_q.push_back(rd);
   endtask

   task automatic push_rsp(input logic [63:0] rd, input logic e);
      rsp_t r;
      r.rdata = rd; r.err = e;
      exp_rsp_q.push_back(r);
   endtask

   // One request through the selected DUT. stall: cycles mem_req_ready is
   // held low on the first beat; hold: cycles rsp_ready is held low;
   // exp_lat: accept-to-rsp_valid cycles (0 = skip); abort: reset in B1_WAIT.
   task automatic access(input logic s, input logic [63:0] a, input logic [2:0] op,
                         input logic w, input logic [63:0] wd, input int stall,
                         input int hold, input int exp_lat, input bit abort);
      int    cyc = 0;
      int    beat_no = 0;
      int    stall_left = stall;
      int    hold_left = hold;
      bit    done = 0;
      bit    rsp_due = 0;
      bit    rsp_seen = 0;
      bit    finishing = 0;
      bit    saw_valid;
      beat_t eb;
      rsp_t  er;
      @(posedge clk); #1;
      sel = s; req_valid = 1'b1; req_addr = a; req_memop = op; req_wen = w; req_wdata = wd;
      rsp_ready = (hold == 0); mem_ready = (stall == 0);
      @(negedge clk);
      check("req_ready_idle", o_req_ready, 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = '0; req_memop = '0; req_wen = 1'b0; req_wdata = '0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         saw_valid = o_mem_req_valid;
         if (finishing) begin
            check("rsp_valid_dropped", o_rsp_valid, 64'd0);
            check("req_ready_after",   o_req_ready, 64'd1);
            done = 1;
            break;
         end
         if (o_mem_req_valid) begin
            if (exp_beat_q.size() == 0) begin
               check("unexpected_beat", 64'd1, 64'd0);
               done = 1;
               break;
            end
            eb = exp_beat_q[0];
            check("beat_addr", o_mem_addr,  eb.addr);
            check("beat_wen",  o_mem_wen,   {63'd0, eb.wen});
            check("beat_mask", o_mem_wmask, {56'd0, eb.mask});
            if (eb.wen) check("beat_wdata", o_mem_wdata, eb.wdata);
            if (mem_ready) begin
               void'(exp_beat_q.pop_front());
               rsp_due = 1;
               beat_no++;
            end
         end
         if (abort && beat_no == 2) break;
         if (o_rsp_valid) begin
            if (exp_rsp_q.size() == 0) begin
               check("unexpected_rsp", 64'd1, 64'd0);
               done = 1;
               break;
            end
            er = exp_rsp_q[0];
            if (!rsp_seen && exp_lat > 0) check("latency", 64'(cyc + 1), 64'(exp_lat));
            rsp_seen = 1;
            check("rsp_rdata", o_rsp_rdata, er.rdata);
            check("rsp_err",   o_rsp_err,   {63'd0, er.err});
            if (rsp_ready) begin
               void'(exp_rsp_q.pop_front());
               finishing = 1;
            end else begin
               hold_left--;
            end
         end
         @(posedge clk); #1;
         mem_rsp_valid = 1'b0;
         if (rsp_due) begin
            mem_rsp_valid = 1'b1;
            mem_rdata = mem_data_q.pop_front();
            rsp_due = 0;
         end
         if (stall_left > 0 && saw_valid) begin
            stall_left--;
            if (stall_left == 0) mem_ready = 1'b1;
         end
         if (finishing) rsp_ready = 1'b0;
         else if (rsp_seen && hold_left <= 0) rsp_ready = 1'b1;
      end
      if (abort) begin
         @(posedge clk); #1;
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         mem_rsp_valid = 1'b1;
         mem_rdata = mem_data_q.pop_front();
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_reset_outputs("abort");
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
         end
         done = 1;
      end
      if (!done) check("timeout", 64'd0, 64'd1);
      mem_rsp_valid = 1'b0;
      rsp_ready = 1'b0;
      $display("[TB] access dut=%0d addr=%h memop=%b wen=%0d cycles=%0d", s, a, op, w, cyc);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      sel = 1'b0; #1;
      check_reset_outputs("reset_dut0");
      sel = 1'b1; #1;
      check_reset_outputs("reset_dut1");
      sel = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // aligned 8B load
      push_beat(64'h0000_0000_8000_0010, 1'b0, 64'd0, 8'h00, 64'h1122_3344_5566_7788);
      push_rsp(64'h1122_3344_5566_7788, 1'b0);
      access(1'b0, 64'h0000_0000_8000_0010, 3'b000, 1'b0, 64'd0, 0, 0, 4, 1'b0);

      // signed and unsigned byte load
      push_beat(64'h0000_0000_8000_0000, 1'b0, 64'd0, 8'h00, 64'h0000_0000_8000_0000);
      push_rsp(64'hFFFF_FFFF_FFFF_FF80, 1'b0);
      access(1'b0, 64'h0000_0000_8000_0003, 3'b111, 1'b0, 64'd0, 0, 0, 4, 1'b0);
      push_beat(64'h0000_0000_8000_0000, 1'b0, 64'd0, 8'h00, 64'h0000_0000_8000_0000);
      push_rsp(64'h0000_0000_0000_0080, 1'b0);
      access(1'b0, 64'h0000_0000_8000_0003, 3'b011, 1'b0, 64'd0, 0, 0, 4, 1'b0);

      // split 4B store
      push_beat(64'h0000_0000_8000_0000, 1'b1, 64'hBEEF_0000_0000_0000, 8'hC0, 64'd0);
      push_beat(64'h0000_0000_8000_0008, 1'b1, 64'h0000_0000_0000_DEAD, 8'h03, 64'd0);
      push_rsp(64'd0, 1'b0);
      access(1'b0, 64'h0000_0000_8000_0006, 3'b001, 1'b1, 64'h0000_0000_DEAD_BEEF, 0, 0, 6, 1'b0);

      // 8B load wrapping past the top of the address space
      push_beat(64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'd0, 8'h00, 64'hAAAA_BBBB_CCCC_DDDD);
      push_beat(64'h0000_0000_0000_0000, 1'b0, 64'd0, 8'h00, 64'h1111_2222_3333_4444);
      push_rsp(64'h3333_4444_AAAA_BBBB, 1'b0);
      access(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 3'b000, 1'b0, 64'd0, 0, 0, 6, 1'b0);

      // split signed halfword with memory stall and response back-pressure
      push_beat(64'h0000_0000_0000_1000, 1'b0, 64'd0, 8'h00, 64'hAB00_0000_0000_0000);
      push_beat(64'h0000_0000_0000_1008, 1'b0, 64'd0, 8'h00, 64'h0000_0000_0000_00CD);
      push_rsp(64'hFFFF_FFFF_FFFF_CDAB, 1'b0);
      access(1'b0, 64'h0000_0000_0000_1007, 3'b110, 1'b0, 64'd0, 2, 1, 0, 1'b0);

      // splitting disabled: crossing refused, aligned access still served
      push_rsp(64'd0, 1'b1);
      access(1'b1, 64'h0000_0000_8000_0007, 3'b010, 1'b0, 64'd0, 0, 0, 0, 1'b0);
      push_beat(64'h0000_0000_8000_0000, 1'b0, 64'd0, 8'h00, 64'h0000_0000_8001_0000);
      push_rsp(64'hFFFF_FFFF_FFFF_8001, 1'b0);
      access(1'b1, 64'h0000_0000_8000_0002, 3'b110, 1'b0, 64'd0, 0, 0, 4, 1'b0);

      // reset in B1_WAIT, stale beat response afterwards
      push_beat(64'h0000_0000_0000_4000, 1'b0, 64'd0, 8'h00, 64'h0000_0000_0000_0001);
      push_beat(64'h0000_0000_0000_4008, 1'b0, 64'd0, 8'h00, 64'h0000_0000_0000_0002);
      access(1'b0, 64'h0000_0000_0000_4004, 3'b000, 1'b0, 64'd0, 0, 0, 0, 1'b1);

      // recovery: byte store and aligned 8B store
      push_beat(64'h0000_0000_0000_2000, 1'b1, 64'h0000_5A00_0000_0000, 8'h20, 64'd0);
      push_rsp(64'd0, 1'b0);
      access(1'b0, 64'h0000_0000_0000_2005, 3'b011, 1'b1, 64'h0000_0000_0000_005A, 0, 0, 4, 1'b0);
      push_beat(64'h0000_0000_0000_3000, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0);
      push_rsp(64'd0, 1'b0);
      access(1'b0, 64'h0000_0000_0000_3000, 3'b000, 1'b1, 64'h0123_4567_89AB_CDEF, 0, 0, 4, 1'b0);

      check("beats_left", 64'(exp_beat_q.size()), 64'd0);
      check("rsps_left",  64'(exp_rsp_q.size()),  64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Multi-cycle load/store sequencer between the execute stage and a single 8-byte-aligned memory port. It latches one request and splits any access that crosses an 8-byte boundary into two aligned beats. It generates byte masks and shifted write data, then reassembles read data with zero or sign extension. Only one access is in flight at a time; the core stalls on req_ready.

Parameters:
ADDR_W, 64, address width; beat addresses wrap modulo 2^ADDR_W.
SPLIT_EN, 1, 1 = boundary-crossing accesses become two beats; 0 = such accesses are not issued and complete immediately with rsp_err=1.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  core request valid
req_ready  out  1  controller accepts a request (IDLE only)
req_addr  in  ADDR_W  byte address
req_memop  in  3  [1:0] size: 3=1B, 2=2B, 1=4B, 0=8B; [2] sign-extend on load; ignored for 8B
req_wen  in  1  1 = store, 0 = load
req_wdata  in  64  store data, right-aligned
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  core accepts response
rsp_rdata  out  64  extended load data; 0 for stores
rsp_err  out  1  misaligned-split refused (SPLIT_EN=0 only)
mem_req_valid  out  1  beat request valid
mem_req_ready  in  1  memory accepts beat
mem_addr  out  ADDR_W  8-byte-aligned beat address (low 3 bits 0)
mem_wen  out  1  beat is a write
mem_wdata  out  64  beat write data
mem_wmask  out  8  beat byte-enable
mem_rsp_valid  in  1  beat completion (reads and writes), one pulse per beat
mem_rsp_rdata  in  64  beat read data

Behaviour:
- Reset: all outputs 0 except req_ready=1. FSM goes to IDLE; latched request cleared. Reset mid-operation abandons the access; any mem_rsp_valid arriving in IDLE is ignored.
- Size bytes: n = 1, 2, 4, 8 for size codes 3, 2, 1, 0. off = addr[2:0]. bytemask = (1<<n)-1.
- Write image: wide data = {64'd0, wdata} << (off*8); wide mask = {8'd0, bytemask} << off. Beat0 uses the low halves; beat1 uses the high halves.
- Split: two_beat = (off + n > 8). Beat0 address = addr & ~7. Beat1 address = beat0 + 8, wrapping silently at the top of the address space.
- FSM states: IDLE, B0_REQ, B0_WAIT, B1_REQ, B1_WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch the request.
  - If two_beat and SPLIT_EN=0: go to RESP with rsp_err=1 and rsp_rdata=0.
  - Otherwise: go to B0_REQ.
- B0_REQ: mem_req_valid=1; address, data and mask must stay stable until mem_req_ready. On handshake, go to B0_WAIT.
- B0_WAIT: on mem_rsp_valid, capture rdata into the low buffer. Next state is B1_REQ if two_beat, else RESP.
- B1_REQ / B1_WAIT: same as beat 0, using the high halves. Read data goes to the high buffer. Then go to RESP.
- mem_rsp_valid in the same cycle as the request handshake is not legal. The memory responds no earlier than the cycle after the handshake.
- RESP: rsp_valid=1.
  - Load result: r = {hi, lo} >> (off*8), then truncated to n bytes and zero- or sign-extended per memop[2].
  - Single-beat loads treat hi as 0.
  - Stores return rsp_rdata=0.
  - On rsp_ready, go to IDLE. A new request is accepted the next cycle; there is no same-cycle bypass.
- Minimum latency, with a zero-wait memory: one beat = 4 cycles from accept to rsp_valid; two beats = 6 cycles.
- mem_wen equals the latched wen for both beats. mem_wmask is 0 on read beats.

Decomposition:
- Shared package holds:
  - memop size codes: MEMOP_B=3, MEMOP_H=2, MEMOP_W=1, MEMOP_D=0, and MEMOP_SIGN bit index 2;
  - the state enum;
  - the size-to-bytemask function.
- Sub-module lsu_align: combinational; computes the write image, wide mask, two_beat flag and load extraction/extension. It is shared by the verification model.

Test Plan:
- Aligned 8B load at 0x8000_0010, memory returns 0x1122334455667788 -> one beat at 0x8000_0010, mask 0, rsp_rdata=0x1122334455667788.
- Signed 1B load at 0x8000_0003 (memop=3'b111), beat data 0x00000000_80000000 -> rsp_rdata=0xFFFFFFFFFFFFFF80; unsigned (3'b011) -> 0x80.
- 4B store 0xDEADBEEF at 0x8000_0006 -> beat0 at 0x8000_0000, mask 0xC0, wdata[63:48]=0xBEEF; beat1 at 0x8000_0008, mask 0x03, wdata[15:0]=0xDEAD.
- 8B load at 0xFFFF_FFFF_FFFF_FFFC -> beat1 address wraps to 0x0; result = {beat1[31:0], beat0[63:32]}.
- SPLIT_EN=0, 2B load at 0x...7 -> no mem_req_valid; rsp_valid with rsp_err=1, rsp_rdata=0.
- rst asserted in B1_WAIT, then late mem_rsp_valid -> outputs return to reset values, req_ready=1, the stale response is ignored and no rsp_valid is produced.
